// File: rtl/fifo_pop_reader.sv
// fifo_pop_reader: drains a push/pop circular-pointer FIFO and re-presents its
// entries on a valid/ready stream through a 2-entry skid buffer. It sustains
// one pop per cycle while the sink is ready and holds data under back-pressure.
//
// Optional feature: define FIFO_POP_READER_FLUSH_EN to add the 'flush' input.
// While flush=1, the FIFO is drained, the popped data is discarded and
// m_valid is forced low.
//
// Ports:
//   clk        clock; all state updates on posedge
//   rst        synchronous reset, active-high
//   flush      (FIFO_POP_READER_FLUSH_EN only) discard buffer and drain FIFO
//   fifo_empty FIFO empty flag
//   fifo_data  FIFO head entry, combinational, valid when fifo_empty=0
//   fifo_pop   pop strobe to the FIFO (combinational)
//   m_valid    stream data valid
//   m_ready    stream sink ready
//   m_data     stream data, oldest buffered entry
//   out_count  stream transfers since reset, wrapping
module fifo_pop_reader #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNTWID = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FIFO_POP_READER_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_data,
  output logic              fifo_pop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic [CNTWID-1:0] out_count
);

  // Buffer occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state;
  logic             valid_q;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             flush_c;
  logic             xfer;

`ifdef FIFO_POP_READER_FLUSH_EN
  // Flush hides the buffered head so no transfer can happen in that cycle.
  assign flush_c = flush;
  assign m_valid = valid_q & ~flush;
`else
  assign flush_c = 1'b0;
  assign m_valid = valid_q;
`endif

  assign m_data = slot0;
  assign xfer   = m_valid & m_ready;

  // Pop whenever there is room now or room is being made by a transfer;
  // during flush pop unconditionally so the FIFO drains.
  assign fifo_pop = ~rst & ~fifo_empty & (flush_c | (state != ST_TWO) | xfer);

  // Skid buffer state machine; fifo_data is captured on the edge that pops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      valid_q   <= 1'b0;
      slot0     <= '0;
      slot1     <= '0;
      out_count <= '0;
    end else if (flush_c) begin
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
    end else begin
      if (xfer) begin
        out_count <= out_count + CNTWID'(1);
      end
      case (state)
        ST_EMPTY: begin
          if (fifo_pop) begin
            slot0   <= fifo_data;
            state   <= ST_ONE;
            valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (fifo_pop && xfer) begin
            slot0 <= fifo_data;
          end else if (fifo_pop) begin
            slot1 <= fifo_data;
            state <= ST_TWO;
          end else if (xfer) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          // A pop only occurs here together with a transfer.
          if (xfer) begin
            slot0 <= slot1;
            if (fifo_pop) begin
              slot1 <= fifo_data;
            end else begin
              state <= ST_ONE;
            end
          end
        end
        default: begin
          state   <= ST_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
